// File: rtl/elastic_pkg.sv
// elastic_pkg: SKP symbol constants, read-controller state type and address-width helper.
package elastic_pkg;
    localparam logic [9:0] SKP_RDN = 10'h0F4;
    localparam logic [9:0] SKP_RDP = 10'h30B;

    typedef enum logic [1:0] {FILL, RUN, INSERT} state_e;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: two-flop synchronizer for a Gray pointer followed by Gray-to-binary conversion.
module gray_ptr_sync #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);
    logic [W-1:0] s1_q, s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= gray_i;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < W; i++) bin_o[i] = ^(s2_q >> i);
    end
endmodule

// File: rtl/elastic_read_ctrl.sv
// elastic_read_ctrl: read side of an elastic buffer with FILL/RUN control and optional SKP insertion.
// Define ELASTIC_SKP_INSERT_EN to enable the INSERT state and the skp_added pulse.
module elastic_read_ctrl
    import elastic_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 10,
    parameter int                    BUFFER_DEPTH = 16,
    parameter int                    LOW_WM       = 4,
    parameter logic [DATA_WIDTH-1:0] SKP_SYMBOL   = DATA_WIDTH'(SKP_RDN),
    localparam int                   ADDR         = addr_w(BUFFER_DEPTH)
) (
    input  logic                  read_clk,
    input  logic                  rst_n,
    input  logic [ADDR:0]         write_ptr_gray,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR-1:0]       read_pointer,
    output logic [ADDR:0]         read_ptr_gray,
    output logic                  rd_en,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  skp_added,
    output logic                  underflow
);
`ifdef ELASTIC_SKP_INSERT_EN
    localparam bit INS_EN = 1'b1;
`else
    localparam bit INS_EN = 1'b0;
`endif
    localparam logic [ADDR:0] HALF  = (ADDR+1)'(BUFFER_DEPTH / 2);
    localparam logic [ADDR:0] LOW_C = (ADDR+1)'(LOW_WM);

    state_e                state_q, state_d;
    logic [ADDR:0]         wptr_bin, fill, rptr_q, rptr_inc, rgray_q;
    logic                  mv_q, skid_v_q, rx_valid_q, under_q, is_skp, ins_go, hold;
    logic [DATA_WIDTH-1:0] skid_q, rx_data_q;

    gray_ptr_sync #(.W(ADDR + 1)) u_sync (
        .clk    (read_clk),
        .rst_n  (rst_n),
        .gray_i (write_ptr_gray),
        .bin_o  (wptr_bin)
    );

    assign fill     = wptr_bin - rptr_q;
    assign empty    = fill == '0;
    assign rptr_inc = rptr_q + (ADDR+1)'(1);
    assign is_skp   = rx_valid_q && (rx_data_q == SKP_SYMBOL || rx_data_q == DATA_WIDTH'(SKP_RDP));
    assign ins_go   = INS_EN && is_skp && fill <= LOW_C;
    // Freeze the output register for the repeat; a word already leaving memory parks in the skid slot.
    assign hold     = state_q == RUN && !empty && ins_go;

    always_ff @(posedge read_clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == FILL ? (fill >= HALF ? RUN : FILL) :
                  state_q == RUN  ? (empty ? FILL : ins_go ? INSERT : RUN) : RUN;
    end

    always_comb begin
        rd_en     = state_q == RUN && !empty;
        skp_added = INS_EN && state_q == INSERT;
    end

    always_ff @(posedge read_clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q     <= '0;
            rgray_q    <= '0;
            mv_q       <= 1'b0;
            skid_q     <= '0;
            skid_v_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            under_q    <= 1'b0;
        end else begin
            mv_q <= rd_en;
            if (rd_en) begin
                rptr_q  <= rptr_inc;
                rgray_q <= rptr_inc ^ (rptr_inc >> 1);
            end
            if (state_q == RUN && empty) under_q <= 1'b1;
            if (hold) begin
                if (mv_q) begin
                    skid_q   <= mem_data;
                    skid_v_q <= 1'b1;
                end
            end else begin
                rx_valid_q <= skid_v_q || mv_q;
                if (skid_v_q || mv_q) rx_data_q <= skid_v_q ? skid_q : mem_data;
                skid_q     <= mem_data;
                skid_v_q   <= skid_v_q && mv_q;
            end
        end
    end

    assign read_pointer  = rptr_q[ADDR-1:0];
    assign read_ptr_gray = rgray_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign underflow     = under_q;
endmodule
